// File: rtl/sub_bytes_seq_pkg.sv
// Shared definitions for the AES byte-substitution stages.
// Holds state width, byte count, FSM encoding and byte-lane addressing.
package sub_bytes_seq_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_BYTES   = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bit position of the least significant bit of byte 'idx' within a state word.
   function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
      return {idx, 3'b000};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box (FIPS-197), purely combinational.
// The table is written out so synthesis can map it freely.
module aes_sbox (
   input  logic [7:0] val,
   output logic [7:0] sub
);

   always_comb begin
      case (val)
         8'h00: sub = 8'h63; 8'h01: sub = 8'h7c; 8'h02: sub = 8'h77; 8'h03: sub = 8'h7b; 8'h04: sub = 8'hf2; 8'h05: sub = 8'h6b; 8'h06: sub = 8'h6f; 8'h07: sub = 8'hc5;
         8'h08: sub = 8'h30; 8'h09: sub = 8'h01; 8'h0a: sub = 8'h67; 8'h0b: sub = 8'h2b; 8'h0c: sub = 8'hfe; 8'h0d: sub = 8'hd7; 8'h0e: sub = 8'hab; 8'h0f: sub = 8'h76;
         8'h10: sub = 8'hca; 8'h11: sub = 8'h82; 8'h12: sub = 8'hc9; 8'h13: sub = 8'h7d; 8'h14: sub = 8'hfa; 8'h15: sub = 8'h59; 8'h16: sub = 8'h47; 8'h17: sub = 8'hf0;
         8'h18: sub = 8'had; 8'h19: sub = 8'hd4; 8'h1a: sub = 8'ha2; 8'h1b: sub = 8'haf; 8'h1c: sub = 8'h9c; 8'h1d: sub = 8'ha4; 8'h1e: sub = 8'h72; 8'h1f: sub = 8'hc0;
         8'h20: sub = 8'hb7; 8'h21: sub = 8'hfd; 8'h22: sub = 8'h93; 8'h23: sub = 8'h26; 8'h24: sub = 8'h36; 8'h25: sub = 8'h3f; 8'h26: sub = 8'hf7; 8'h27: sub = 8'hcc;
         8'h28: sub = 8'h34; 8'h29: sub = 8'ha5; 8'h2a: sub = 8'he5; 8'h2b: sub = 8'hf1; 8'h2c: sub = 8'h71; 8'h2d: sub = 8'hd8; 8'h2e: sub = 8'h31; 8'h2f: sub = 8'h15;
         8'h30: sub = 8'h04; 8'h31: sub = 8'hc7; 8'h32: sub = 8'h23; 8'h33: sub = 8'hc3; 8'h34: sub = 8'h18; 8'h35: sub = 8'h96; 8'h36: sub = 8'h05; 8'h37: sub = 8'h9a;
         8'h38: sub = 8'h07; 8'h39: sub = 8'h12; 8'h3a: sub = 8'h80; 8'h3b: sub = 8'he2; 8'h3c: sub = 8'heb; 8'h3d: sub = 8'h27; 8'h3e: sub = 8'hb2; 8'h3f: sub = 8'h75;
         8'h40: sub = 8'h09; 8'h41: sub = 8'h83; 8'h42: sub = 8'h2c; 8'h43: sub = 8'h1a; 8'h44: sub = 8'h1b; 8'h45: sub = 8'h6e; 8'h46: sub = 8'h5a; 8'h47: sub = 8'ha0;
         8'h48: sub = 8'h52; 8'h49: sub = 8'h3b; 8'h4a: sub = 8'hd6; 8'h4b: sub = 8'hb3; 8'h4c: sub = 8'h29; 8'h4d: sub = 8'he3; 8'h4e: sub = 8'h2f; 8'h4f: sub = 8'h84;
         8'h50: sub = 8'h53; 8'h51: sub = 8'hd1; 8'h52: sub = 8'h00; 8'h53: sub = 8'hed; 8'h54: sub = 8'h20; 8'h55: sub = 8'hfc; 8'h56: sub = 8'hb1; 8'h57: sub = 8'h5b;
         8'h58: sub = 8'h6a; 8'h59: sub = 8'hcb; 8'h5a: sub = 8'hbe; 8'h5b: sub = 8'h39; 8'h5c: sub = 8'h4a; 8'h5d: sub = 8'h4c; 8'h5e: sub = 8'h58; 8'h5f: sub = 8'hcf;
         8'h60: sub = 8'hd0; 8'h61: sub = 8'hef; 8'h62: sub = 8'haa; 8'h63: sub = 8'hfb; 8'h64: sub = 8'h43; 8'h65: sub = 8'h4d; 8'h66: sub = 8'h33; 8'h67: sub = 8'h85;
         8'h68: sub = 8'h45; 8'h69: sub = 8'hf9; 8'h6a: sub = 8'h02; 8'h6b: sub = 8'h7f; 8'h6c: sub = 8'h50; 8'h6d: sub = 8'h3c; 8'h6e: sub = 8'h9f; 8'h6f: sub = 8'ha8;
         8'h70: sub = 8'h51; 8'h71: sub = 8'ha3; 8'h72: sub = 8'h40; 8'h73: sub = 8'h8f; 8'h74: sub = 8'h92; 8'h75: sub = 8'h9d; 8'h76: sub = 8'h38; 8'h77: sub = 8'hf5;
         8'h78: sub = 8'hbc; 8'h79: sub = 8'hb6; 8'h7a: sub = 8'hda; 8'h7b: sub = 8'h21; 8'h7c: sub = 8'h10; 8'h7d: sub = 8'hff; 8'h7e: sub = 8'hf3; 8'h7f: sub = 8'hd2;
         8'h80: sub = 8'hcd; 8'h81: sub = 8'h0c; 8'h82: sub = 8'h13; 8'h83: sub = 8'hec; 8'h84: sub = 8'h5f; 8'h85: sub = 8'h97; 8'h86: sub = 8'h44; 8'h87: sub = 8'h17;
         8'h88: sub = 8'hc4; 8'h89: sub = 8'ha7; 8'h8a: sub = 8'h7e; 8'h8b: sub = 8'h3d; 8'h8c: sub = 8'h64; 8'h8d: sub = 8'h5d; 8'h8e: sub = 8'h19; 8'h8f: sub = 8'h73;
         8'h90: sub = 8'h60; 8'h91: sub = 8'h81; 8'h92: sub = 8'h4f; 8'h93: sub = 8'hdc; 8'h94: sub = 8'h22; 8'h95: sub = 8'h2a; 8'h96: sub = 8'h90; 8'h97: sub = 8'h88;
         8'h98: sub = 8'h46; 8'h99: sub = 8'hee; 8'h9a: sub = 8'hb8; 8'h9b: sub = 8'h14; 8'h9c: sub = 8'hde; 8'h9d: sub = 8'h5e; 8'h9e: sub = 8'h0b; 8'h9f: sub = 8'hdb;
         8'ha0: sub = 8'he0; 8'ha1: sub = 8'h32; 8'ha2: sub = 8'h3a; 8'ha3: sub = 8'h0a; 8'ha4: sub = 8'h49; 8'ha5: sub = 8'h06; 8'ha6: sub = 8'h24; 8'ha7: sub = 8'h5c;
         8'ha8: sub = 8'hc2; 8'ha9: sub = 8'hd3; 8'haa: sub = 8'hac; 8'hab: sub = 8'h62; 8'hac: sub = 8'h91; 8'had: sub = 8'h95; 8'hae: sub = 8'he4; 8'haf: sub = 8'h79;
         8'hb0: sub = 8'he7; 8'hb1: sub = 8'hc8; 8'hb2: sub = 8'h37; 8'hb3: sub = 8'h6d; 8'hb4: sub = 8'h8d; 8'hb5: sub = 8'hd5; 8'hb6: sub = 8'h4e; 8'hb7: sub = 8'ha9;
         8'hb8: sub = 8'h6c; 8'hb9: sub = 8'h56; 8'hba: sub = 8'hf4; 8'hbb: sub = 8'hea; 8'hbc: sub = 8'h65; 8'hbd: sub = 8'h7a; 8'hbe: sub = 8'hae; 8'hbf: sub = 8'h08;
         8'hc0: sub = 8'hba; 8'hc1: sub = 8'h78; 8'hc2: sub = 8'h25; 8'hc3: sub = 8'h2e; 8'hc4: sub = 8'h1c; 8'hc5: sub = 8'ha6; 8'hc6: sub = 8'hb4; 8'hc7: sub = 8'hc6;
         8'hc8: sub = 8'he8; 8'hc9: sub = 8'hdd; 8'hca: sub = 8'h74; 8'hcb: sub = 8'h1f; 8'hcc: sub = 8'h4b; 8'hcd: sub = 8'hbd; 8'hce: sub = 8'h8b; 8'hcf: sub = 8'h8a;
         8'hd0: sub = 8'h70; 8'hd1: sub = 8'h3e; 8'hd2: sub = 8'hb5; 8'hd3: sub = 8'h66; 8'hd4: sub = 8'h48; 8'hd5: sub = 8'h03; 8'hd6: sub = 8'hf6; 8'hd7: sub = 8'h0e;
         8'hd8: sub = 8'h61; 8'hd9: sub = 8'h35; 8'hda: sub = 8'h57; 8'hdb: sub = 8'hb9; 8'hdc: sub = 8'h86; 8'hdd: sub = 8'hc1; 8'hde: sub = 8'h1d; 8'hdf: sub = 8'h9e;
         8'he0: sub = 8'he1; 8'he1: sub = 8'hf8; 8'he2: sub = 8'h98; 8'he3: sub = 8'h11; 8'he4: sub = 8'h69; 8'he5: sub = 8'hd9; 8'he6: sub = 8'h8e; 8'he7: sub = 8'h94;
         8'he8: sub = 8'h9b; 8'he9: sub = 8'h1e; 8'hea: sub = 8'h87; 8'heb: sub = 8'he9; 8'hec: sub = 8'hce; 8'hed: sub = 8'h55; 8'hee: sub = 8'h28; 8'hef: sub = 8'hdf;
         8'hf0: sub = 8'h8c; 8'hf1: sub = 8'ha1; 8'hf2: sub = 8'h89; 8'hf3: sub = 8'h0d; 8'hf4: sub = 8'hbf; 8'hf5: sub = 8'he6; 8'hf6: sub = 8'h42; 8'hf7: sub = 8'h68;
         8'hf8: sub = 8'h41; 8'hf9: sub = 8'h99; 8'hfa: sub = 8'h2d; 8'hfb: sub = 8'h0f; 8'hfc: sub = 8'hb0; 8'hfd: sub = 8'h54; 8'hfe: sub = 8'hbb; 8'hff: sub = 8'h16;
      endcase
   end

endmodule

// File: rtl/sub_bytes_seq.sv
// Sequential forward SubBytes: latches a state on En, substitutes BPC bytes
// per cycle (MSB byte first) through shared S-boxes, then strobes Ry for one cycle.
module sub_bytes_seq
   import sub_bytes_seq_pkg::*;
#(
   parameter int BPC = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   En,
   input  logic [AES_STATE_W-1:0] PT,
   output logic                   Ry,
   output logic                   Busy,
   output logic [AES_STATE_W-1:0] PT_2
);

   localparam int               N        = AES_BYTES / BPC;
   localparam int               CNT_W    = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
      $error("sub_bytes_seq: BPC must be 1, 2, 4, 8 or 16");
   end

   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [AES_STATE_W-1:0] work;
   logic [AES_STATE_W-1:0] work_sub;
   logic [3:0]             lane_idx [BPC];
   logic [7:0]             lane_in  [BPC];
   logic [7:0]             lane_out [BPC];

   // Lane j handles byte 15 - cnt*BPC - j, so the MSB byte is substituted first.
   for (genvar j = 0; j < BPC; j++) begin : g_lane
      assign lane_idx[j] = 4'(AES_BYTES - 1 - BPC * int'(cnt) - j);
      assign lane_in[j]  = work[byte_lsb(lane_idx[j]) +: 8];

      aes_sbox u_sbox (
         .val (lane_in[j]),
         .sub (lane_out[j])
      );
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
      work_sub = work;
      for (int j = 0; j < BPC; j++) begin
         work_sub[byte_lsb(lane_idx[j]) +: 8] = lane_out[j];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (En) state_nxt = ST_SUB;
         ST_SUB:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      Ry   = (state == ST_DONE);
      Busy = (state != ST_IDLE);
   end

   // NOTE: the working register is cleared on reset so an aborted operation leaves nothing behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         work <= '0;
         PT_2 <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (En) begin
                  work <= PT;
                  cnt  <= '0;
               end
            end
            ST_SUB: begin
               work <= work_sub;
               if (cnt == CNT_LAST) begin
                  cnt  <= '0;
                  PT_2 <= work_sub;
               end else begin
                  cnt  <= cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed bench for sub_bytes_seq at BPC = 1, 4 and 16, with a round trip
// through an inverse S-box derived from its GF(2^8) definition.
module tb_sub_bytes_seq;

   localparam logic [127:0] V_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] V_OUT  = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] RAMP   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] RAMP_S = 128'h637c777bf26b6fc53001672bfed7ab76;
   localparam logic [127:0] ZERO_S = {16{8'h63}};
   localparam logic [127:0] ONES_S = {16{8'h16}};

   logic         clk = 1'b0;
   logic         rst;
   logic         en   [3];
   logic [127:0] pt   [3];
   logic         ry   [3];
   logic         busy [3];
   logic [127:0] q    [3];
   int           lat  [3] = '{17, 5, 2};
   logic [7:0]   inv_tab [256];
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   sub_bytes_seq #(.BPC(1)) u_dut1 (
      .clk(clk), .rst(rst), .En(en[0]), .PT(pt[0]), .Ry(ry[0]), .Busy(busy[0]), .PT_2(q[0])
   );
   sub_bytes_seq #(.BPC(4)) u_dut4 (
      .clk(clk), .rst(rst), .En(en[1]), .PT(pt[1]), .Ry(ry[1]), .Busy(busy[1]), .PT_2(q[1])
   );
   sub_bytes_seq #(.BPC(16)) u_dut16 (
      .clk(clk), .rst(rst), .En(en[2]), .PT(pt[2]), .Ry(ry[2]), .Busy(busy[2]), .PT_2(q[2])
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // GF(2^8) multiply with the AES polynomial.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map.
   function automatic logic [7:0] sbox_model(input logic [7:0] a);
      logic [7:0] b = 8'h00;
      for (int c = 1; c < 256; c++) begin
         if (gmul(a, 8'(c)) == 8'h01) b = 8'(c);
      end
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] inv_state(input logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv_tab[s[i*8 +: 8]];
      return r;
   endfunction

   // Issues one request from an IDLE cycle and waits (bounded) for Ry.
   // k is the cycle index of Ry, counting the cycle after the accepting edge as 1.
   task automatic run_req(input int d, input logic [127:0] p, output int k, output int busy_n);
      pt[d] = p;
      en[d] = 1'b1;
      tick();
      en[d] = 1'b0;
      pt[d] = ~p;
      k      = 1;
      busy_n = 0;
      while (k <= 40) begin
         if (busy[d]) busy_n++;
         if (ry[d]) break;
         tick();
         k++;
      end
   endtask

   task automatic run_vec(input int d, input logic [127:0] p, input logic [127:0] expv, input string tag);
      int k;
      int busy_n;
      run_req(d, p, k, busy_n);
      check({tag, " ry latency"}, 128'(k), 128'(lat[d]));
      check({tag, " result"}, q[d], expv);
      check({tag, " busy cycles"}, 128'(busy_n), 128'(lat[d]));
      tick();
      check({tag, " ry single cycle"}, 128'(ry[d]), 128'(0));
      check({tag, " busy back low"}, 128'(busy[d]), 128'(0));
      check({tag, " result held"}, q[d], expv);
   endtask

   initial begin
      int           k;
      int           busy_n;
      int           ry_seen;
      logic [127:0] r;

      for (int a = 0; a < 256; a++) inv_tab[sbox_model(8'(a))] = 8'(a);

      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         en[d] = 1'b0;
         pt[d] = '0;
      end
      tick();
      tick();
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset ry d%0d", d), 128'(ry[d]), 128'(0));
         check($sformatf("reset busy d%0d", d), 128'(busy[d]), 128'(0));
         check($sformatf("reset pt_2 d%0d", d), q[d], 128'(0));
      end
      rst = 1'b0;
      tick();

      run_vec(0, V_IN, V_OUT, "bpc1 vector");
      run_vec(1, V_IN, V_OUT, "bpc4 vector");
      run_vec(2, V_IN, V_OUT, "bpc16 vector");
      run_vec(0, '0, ZERO_S, "bpc1 zeros");
      run_vec(2, '1, ONES_S, "bpc16 ones");
      run_vec(1, RAMP, RAMP_S, "bpc4 ramp");

      // BPC=4 with En held and toggled and PT changed mid-operation. The second
      // request is taken in the IDLE cycle after DONE, so Ry repeats every N+2 cycles.
      for (int c = 0; c <= 13; c++) begin
         case (c)
            0:       begin pt[1] = '0;   en[1] = 1'b1; end
            1:       begin pt[1] = RAMP; en[1] = 1'b0; end
            2:       en[1] = 1'b1;
            7:       begin pt[1] = '1;   en[1] = 1'b0; end
            8:       en[1] = 1'b1;
            9:       en[1] = 1'b0;
            default: ;
         endcase
         check($sformatf("held en ry cycle %0d", c), 128'(ry[1]), 128'(c == 5 || c == 11));
         if (c == 5)  check("held en first result", q[1], ZERO_S);
         if (c == 11) check("held en second result", q[1], RAMP_S);
         tick();
      end
      check("held en idle afterwards", 128'(busy[1]), 128'(0));

      // Reset during the fifth SUB cycle of a BPC=1 operation.
      pt[0] = V_IN;
      en[0] = 1'b1;
      tick();
      en[0] = 1'b0;
      for (int c = 1; c < 5; c++) tick();
      check("pre-reset busy", 128'(busy[0]), 128'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid-sub reset ry", 128'(ry[0]), 128'(0));
      check("mid-sub reset busy", 128'(busy[0]), 128'(0));
      check("mid-sub reset pt_2", q[0], 128'(0));
      check("mid-sub reset pt_2 bpc16", q[2], 128'(0));
      ry_seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (ry[0]) ry_seen++;
         tick();
      end
      check("no ry after reset", 128'(ry_seen), 128'(0));
      run_vec(0, V_IN, V_OUT, "bpc1 after reset");

      // Reset and En together: the request must be dropped.
      rst   = 1'b1;
      en[2] = 1'b1;
      pt[2] = V_IN;
      tick();
      rst   = 1'b0;
      en[2] = 1'b0;
      check("rst with en busy", 128'(busy[2]), 128'(0));
      tick();
      check("rst with en no ry", 128'(ry[2]), 128'(0));
      check("rst with en pt_2", q[2], 128'(0));

      for (int i = 0; i < 1000; i++) begin
         r = {$urandom, $urandom, $urandom, $urandom};
         run_req(2, r, k, busy_n);
         check($sformatf("round trip %0d", i), inv_state(q[2]), r);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
